// File: rtl/mem_stage_if.sv
// Execute -> memory-stage bundle: the ex_mem register, stall/flush, the data memory
// request/response port and the mem_wb register outputs.
interface mem_stage_if #(parameter int PHYS_W = 6);
  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd_s;
    logic [31:0]       alu_out;
    logic [31:0]       rs2_v;
    logic [31:0]       u_imm;
    logic              br_en;
    logic              regf_we;
    logic [1:0]        regfilemux_sel;
    logic [PHYS_W-1:0] dest_phys_new;
  } ex_mem_stage_reg_t;

  ex_mem_stage_reg_t ex_mem;
  logic              ex_mem_ready;
  logic              flushing_inst;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              mem_wb_valid;
  logic [31:0]       mem_wb_pc;
  logic [4:0]        mem_wb_rd_s;
  logic [PHYS_W-1:0] mem_wb_phys;
  logic              mem_wb_we;
  logic [31:0]       mem_wb_rd_v;
  logic              mem_wb_misalign;

  modport slave (
    input  ex_mem, flushing_inst, dmem_rdata, dmem_resp,
    output ex_mem_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           mem_wb_valid, mem_wb_pc, mem_wb_rd_s, mem_wb_phys, mem_wb_we,
           mem_wb_rd_v, mem_wb_misalign
  );

  modport master (
    output ex_mem, flushing_inst, dmem_rdata, dmem_resp,
    input  ex_mem_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           mem_wb_valid, mem_wb_pc, mem_wb_rd_s, mem_wb_phys, mem_wb_we,
           mem_wb_rd_v, mem_wb_misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: single-outstanding load/store issue with byte-lane alignment, stalls execute
// while a request is in flight, and writes the mem_wb register.
module mem_stage #(parameter int PHYS_W = 6) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state;

  logic              is_load, is_store, is_mem, mis, accept, kill;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [31:0]       wdata, mux_v, lane, ld_v;

  // instruction context held across the outstanding request
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              load_q, we_q, flushed_q;
  logic [31:0]       pc_q;
  logic [4:0]        rd_q;
  logic [PHYS_W-1:0] phys_q;

  assign bus.ex_mem_ready = (state == S_IDLE);
  assign accept = bus.ex_mem.valid & (state == S_IDLE) & ~bus.flushing_inst;
  assign kill   = flushed_q | bus.flushing_inst;

  always_comb begin
    off      = bus.ex_mem.alu_out[1:0];
    is_load  = (bus.ex_mem.opcode == OP_LOAD);
    is_store = (bus.ex_mem.opcode == OP_STORE);
    is_mem   = is_load | is_store;
    mask     = 4'b1111;
    mis      = 1'b0;
    case (bus.ex_mem.funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01:   begin mask = 4'b0011 << off; mis = off[0]; end
      default: begin mask = 4'b1111;        mis = (off != 2'b00); end
    endcase
    mis   = mis & is_mem;
    wdata = bus.ex_mem.rs2_v << {off, 3'b000};
    case (bus.ex_mem.regfilemux_sel)
      2'd0:    mux_v = bus.ex_mem.alu_out;
      2'd1:    mux_v = {31'b0, bus.ex_mem.br_en};
      2'd2:    mux_v = bus.ex_mem.u_imm;
      default: mux_v = bus.ex_mem.pc + 32'd4;
    endcase
  end

  always_comb begin
    lane = bus.dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_v = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_v = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_v = {24'b0, lane[7:0]};
      3'b101:  ld_v = {16'b0, lane[15:0]};
      default: ld_v = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      bus.dmem_addr       <= '0;
      bus.dmem_rmask      <= '0;
      bus.dmem_wmask      <= '0;
      bus.dmem_wdata      <= '0;
      bus.mem_wb_valid    <= 1'b0;
      bus.mem_wb_pc       <= '0;
      bus.mem_wb_rd_s     <= '0;
      bus.mem_wb_phys     <= '0;
      bus.mem_wb_we       <= 1'b0;
      bus.mem_wb_rd_v     <= '0;
      bus.mem_wb_misalign <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
      load_q    <= 1'b0;
      we_q      <= 1'b0;
      flushed_q <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      phys_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mem && !mis) begin
            bus.dmem_addr    <= {bus.ex_mem.alu_out[31:2], 2'b00};
            bus.dmem_rmask   <= is_load  ? mask : 4'b0000;
            bus.dmem_wmask   <= is_store ? mask : 4'b0000;
            bus.dmem_wdata   <= wdata;
            bus.mem_wb_valid <= 1'b0;
            bus.mem_wb_we    <= 1'b0;
            off_q     <= off;
            f3_q      <= bus.ex_mem.funct3;
            load_q    <= is_load;
            we_q      <= bus.ex_mem.regf_we;
            flushed_q <= 1'b0;
            pc_q      <= bus.ex_mem.pc;
            rd_q      <= bus.ex_mem.rd_s;
            phys_q    <= bus.ex_mem.dest_phys_new;
            state     <= S_REQ;
          end else if (accept) begin
            // non-memory op, or a misaligned access retiring without a request
            bus.mem_wb_valid    <= 1'b1;
            bus.mem_wb_pc       <= bus.ex_mem.pc;
            bus.mem_wb_rd_s     <= bus.ex_mem.rd_s;
            bus.mem_wb_phys     <= bus.ex_mem.dest_phys_new;
            bus.mem_wb_we       <= bus.ex_mem.regf_we & ~mis;
            bus.mem_wb_rd_v     <= mis ? 32'b0 : mux_v;
            bus.mem_wb_misalign <= mis;
          end else begin
            bus.mem_wb_valid <= 1'b0;
            bus.mem_wb_we    <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          bus.dmem_rmask <= 4'b0000;
          bus.dmem_wmask <= 4'b0000;
          flushed_q      <= kill;
          if (bus.dmem_resp) begin
            // a flushed op still completes on the bus but does not retire
            bus.mem_wb_valid    <= ~kill;
            bus.mem_wb_pc       <= pc_q;
            bus.mem_wb_rd_s     <= rd_q;
            bus.mem_wb_phys     <= phys_q;
            bus.mem_wb_we       <= we_q & ~kill;
            bus.mem_wb_rd_v     <= load_q ? ld_v : 32'b0;
            bus.mem_wb_misalign <= 1'b0;
            state               <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage against a byte-lane arithmetic reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if #(.PHYS_W(6)) bus();
  mem_stage #(.PHYS_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 alu/jump, 1 load, 2 store
    logic [2:0]  f3;
    logic [31:0] pc, alu, rs2, uimm, rdata;
    logic        br, we;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [5:0]  phys;
  } op_t;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input int kind, input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] rs2, input logic [31:0] rdata, input logic [1:0] sel);
    op_t o;
    o.kind = kind; o.f3 = f3; o.alu = alu; o.rs2 = rs2; o.rdata = rdata; o.sel = sel;
    o.pc   = $urandom & 32'hFFFF_FFFC;
    o.uimm = $urandom & 32'hFFFF_F000;
    o.br   = 1'($urandom);
    o.we   = (kind != 2);
    o.rd   = 5'($urandom);
    o.phys = 6'($urandom);
    return o;
  endfunction

  function automatic logic [31:0] exp_mux(input op_t o);
    case (o.sel)
      2'd0:    return o.alu;
      2'd1:    return o.br ? 32'd1 : 32'd0;
      2'd2:    return o.uimm;
      default: return o.pc + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [31:0] s, b, h;
    s = rdata >> (8 * off);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return s;
    endcase
  endfunction

  task automatic drive(input op_t o);
    bus.ex_mem.valid          = 1'b1;
    bus.ex_mem.pc             = o.pc;
    bus.ex_mem.opcode         = (o.kind == 1) ? 7'b0000011 : (o.kind == 2) ? 7'b0100011 : 7'b0110011;
    bus.ex_mem.funct3         = o.f3;
    bus.ex_mem.rd_s           = o.rd;
    bus.ex_mem.alu_out        = o.alu;
    bus.ex_mem.rs2_v          = o.rs2;
    bus.ex_mem.u_imm          = o.uimm;
    bus.ex_mem.br_en          = o.br;
    bus.ex_mem.regf_we        = o.we;
    bus.ex_mem.regfilemux_sel = o.sel;
    bus.ex_mem.dest_phys_new  = o.phys;
  endtask

  task automatic do_op(input op_t o, input int lat, input bit fl_idle, input bit fl_mid);
    int          off, nb;
    bit          is_mem, mis;
    logic [3:0]  m;
    off    = int'(o.alu % 4);
    nb     = 1 << o.f3[1:0];
    is_mem = (o.kind != 0);
    mis    = is_mem && (off % nb != 0);
    m      = 4'(((1 << nb) - 1) << off);
    chk("ready_before", 32'(bus.ex_mem_ready), 32'd1);
    drive(o);
    bus.flushing_inst = fl_idle;
    step();
    bus.ex_mem.valid  = 1'b0;
    bus.flushing_inst = 1'b0;
    if (fl_idle) begin
      chk("flush_idle_valid", 32'(bus.mem_wb_valid), 32'd0);
      chk("flush_idle_rmask", 32'(bus.dmem_rmask | bus.dmem_wmask), 32'd0);
      return;
    end
    if (!is_mem || mis) begin
      chk("wb_valid", 32'(bus.mem_wb_valid), 32'd1);
      chk("wb_pc", bus.mem_wb_pc, o.pc);
      chk("wb_rd", 32'(bus.mem_wb_rd_s), 32'(o.rd));
      chk("wb_phys", 32'(bus.mem_wb_phys), 32'(o.phys));
      chk("wb_we", 32'(bus.mem_wb_we), 32'(o.we & !mis));
      chk("wb_misalign", 32'(bus.mem_wb_misalign), 32'(mis));
      chk("no_req_mask", 32'(bus.dmem_rmask | bus.dmem_wmask), 32'd0);
      if (!mis) chk("wb_rd_v", bus.mem_wb_rd_v, exp_mux(o));
      return;
    end
    chk("req_addr", bus.dmem_addr, o.alu - 32'(off));
    chk("req_rmask", 32'(bus.dmem_rmask), (o.kind == 1) ? 32'(m) : 32'd0);
    chk("req_wmask", 32'(bus.dmem_wmask), (o.kind == 2) ? 32'(m) : 32'd0);
    if (o.kind == 2) chk("req_wdata", bus.dmem_wdata, o.rs2 << (8 * off));
    chk("req_ready", 32'(bus.ex_mem_ready), 32'd0);
    chk("req_wb_valid", 32'(bus.mem_wb_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_masks", 32'(bus.dmem_rmask | bus.dmem_wmask), 32'd0);
      chk("wait_addr", bus.dmem_addr, o.alu - 32'(off));
      chk("wait_ready", 32'(bus.ex_mem_ready), 32'd0);
      chk("wait_wb_valid", 32'(bus.mem_wb_valid), 32'd0);
    end
    bus.dmem_resp     = 1'b1;
    bus.dmem_rdata    = o.rdata;
    bus.flushing_inst = fl_mid;
    step();
    bus.dmem_resp     = 1'b0;
    bus.flushing_inst = 1'b0;
    chk("done_valid", 32'(bus.mem_wb_valid), 32'(!fl_mid));
    chk("done_we", 32'(bus.mem_wb_we), 32'(o.we & !fl_mid));
    chk("done_ready", 32'(bus.ex_mem_ready), 32'd1);
    if (!fl_mid) begin
      chk("done_pc", bus.mem_wb_pc, o.pc);
      chk("done_phys", 32'(bus.mem_wb_phys), 32'(o.phys));
      chk("done_misalign", 32'(bus.mem_wb_misalign), 32'd0);
      if (o.kind == 1) chk("done_rd_v", bus.mem_wb_rd_v, exp_load(o.f3, off, o.rdata));
    end
  endtask

  initial begin
    op_t o;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    rst = 1'b1;
    bus.ex_mem = '0;
    bus.flushing_inst = 1'b0;
    bus.dmem_rdata = '0;
    bus.dmem_resp = 1'b0;
    step(); step();
    chk("rst_ready", 32'(bus.ex_mem_ready), 32'd1);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_wb", 32'({bus.mem_wb_valid, bus.mem_wb_we, bus.mem_wb_misalign}), 32'd0);
    chk("rst_wb_rd_v", bus.mem_wb_rd_v, 32'd0);
    rst = 1'b0;
    step();

    do_op(mk(1, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 0), 3, 0, 0);  // LW, late response
    do_op(mk(1, 3'b000, 32'h1003, 0, 32'h80AABBCC, 0), 1, 0, 0);  // LB
    do_op(mk(1, 3'b100, 32'h1003, 0, 32'h80AABBCC, 0), 2, 0, 0);  // LBU
    do_op(mk(2, 3'b001, 32'h1002, 32'h00001234, 0, 0), 1, 0, 0);  // SH
    do_op(mk(0, 3'b000, 32'd5, 0, 0, 2'd0), 0, 0, 0);             // ADD
    do_op(mk(0, 3'b000, 32'd9, 0, 0, 2'd3), 0, 0, 0);             // JAL, next cycle
    step();
    chk("idle_no_valid", 32'(bus.mem_wb_valid), 32'd0);
    do_op(mk(1, 3'b010, 32'h1002, 0, 0, 0), 0, 0, 0);             // misaligned LW
    do_op(mk(1, 3'b010, 32'h2004, 0, 32'h01234567, 0), 0, 0, 0);  // response in REQ cycle
    do_op(mk(1, 3'b001, 32'h2006, 0, 32'h8001FFFF, 0), 2, 0, 1);  // flush during WAIT
    do_op(mk(1, 3'b010, 32'h2008, 0, 0, 0), 0, 1, 0);             // flush in IDLE

    // reset while waiting, then a stray response
    o = mk(1, 3'b010, 32'h3000, 0, 32'hCAFEF00D, 0);
    drive(o);
    step();
    bus.ex_mem.valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.ex_mem_ready), 32'd1);
    chk("midrst_addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = o.rdata;
    step();
    bus.dmem_resp = 1'b0;
    chk("stray_valid", 32'(bus.mem_wb_valid), 32'd0);
    chk("stray_rd_v", bus.mem_wb_rd_v, 32'd0);
    chk("stray_pc", bus.mem_wb_pc, 32'd0);
    chk("stray_masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);

    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      o = mk(kind, f3, $urandom, $urandom, $urandom, 2'($urandom));
      do_op(o, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
            (kind != 0) && ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("rand_idle_valid", 32'(bus.mem_wb_valid), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
